// File: rtl/dcom_buffer_scheduler.sv
// Round-robin refill scheduler: grants one of eight DCOM channels, then streams
// BURST_WORDS 64-bit source words into that channel's data buffer over Avalon-MM.
module dcom_buffer_scheduler #(
  parameter int unsigned BURST_WORDS = 256
) (
  input  logic        clock_sink_clk,
  input  logic        reset_sink_reset,
  input  logic        sched_enable_i,
  input  logic [7:0]  ch_req_i,
  output logic        src_start_o,
  output logic [2:0]  src_ch_o,
  input  logic        src_valid_i,
  input  logic [63:0] src_data_i,
  output logic        src_ready_o,
  output logic [7:0]  buf_chipselect_o,
  output logic [11:0] buf_address_o,
  output logic        buf_write_o,
  output logic [63:0] buf_writedata_o,
  output logic [7:0]  buf_byteenable_o,
  input  logic [7:0]  buf_waitrequest_i,
  output logic [7:0]  ch_done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  localparam logic [12:0] LAST_COUNT = 13'(BURST_WORDS);

  state_t      state;
  logic [2:0]  last_grant;
  logic [12:0] accepted;
  logic [2:0]  next_grant;
  logic        sel_wait;
  logic        write_done;
  logic        accept;

  assign sel_wait   = buf_waitrequest_i[src_ch_o];
  assign write_done = buf_write_o && !sel_wait;
  assign accept     = src_ready_o && src_valid_i;

  // A new word may enter only when the output register is empty or draining this cycle.
  always_comb begin
    src_ready_o = (state == XFER) && (accepted < LAST_COUNT) && (!buf_write_o || !sel_wait);
  end

  // Search begins one past the last served channel; k=8 wraps back to last_grant itself.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    next_grant = last_grant;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = last_grant + 3'(k);
      if (!found && ch_req_i[idx]) begin
        found      = 1'b1;
        next_grant = idx;
      end
    end
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      state            <= IDLE;
      last_grant       <= 3'd7;
      accepted         <= '0;
      src_start_o      <= 1'b0;
      src_ch_o         <= '0;
      buf_chipselect_o <= '0;
      buf_address_o    <= '0;
      buf_write_o      <= 1'b0;
      buf_writedata_o  <= '0;
      buf_byteenable_o <= '0;
      ch_done_o        <= '0;
      busy_o           <= 1'b0;
    end else begin
      buf_byteenable_o <= '1;
      src_start_o      <= 1'b0;
      ch_done_o        <= '0;
      case (state)
        IDLE: begin
          if (sched_enable_i && (ch_req_i != '0)) begin
            state            <= START;
            src_ch_o         <= next_grant;
            buf_chipselect_o <= 8'(1) << next_grant;
            src_start_o      <= 1'b1;
            busy_o           <= 1'b1;
            accepted         <= '0;
          end
        end
        START: state <= XFER;
        XFER: begin
          if (accept) begin
            buf_writedata_o <= src_data_i;
            buf_address_o   <= accepted[11:0];
            buf_write_o     <= 1'b1;
            accepted        <= accepted + 13'd1;
          end else if (write_done) begin
            buf_write_o <= 1'b0;
          end
          if (write_done && (accepted == LAST_COUNT)) begin
            state     <= DONE;
            ch_done_o <= buf_chipselect_o;
          end
        end
        DONE: begin
          state            <= IDLE;
          last_grant       <= src_ch_o;
          buf_chipselect_o <= '0;
          busy_o           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcom_buffer_scheduler.md
DCOM_BUFFER_SCHEDULER -- requirements
Module: dcom_buffer_scheduler

Interface
REQ-001 Parameter BURST_WORDS, default 256, SHALL set the number of 64-bit words written per grant; legal range 1..4096.
REQ-002 clock_sink_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset_sink_reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 sched_enable_i  in  1  SHALL gate new grants; 0 blocks arbitration and does not abort a burst already granted.
REQ-005 ch_req_i  in  8  SHALL carry level refill requests from DCOM channels A..H, bit 0 = A.
REQ-006 src_start_o  out  1  SHALL give a one-cycle pulse telling the DMA source to begin fetching for src_ch_o.
REQ-007 src_ch_o  out  3  SHALL give the index of the granted channel.
REQ-008 src_valid_i  in  1 and src_data_i  in  64  SHALL carry the source word; src_ready_o  out  1  SHALL accept it (transfer = valid AND ready).
REQ-009 buf_chipselect_o  out  8  SHALL be one-hot on the granted channel's data-buffer slave.
REQ-010 buf_address_o  out  12, buf_write_o  out  1, buf_writedata_o  out  64, buf_byteenable_o  out  8  SHALL form the shared Avalon-MM write to the data buffers.
REQ-011 buf_waitrequest_i  in  8  SHALL carry per-channel waitrequest; only the selected bit is used.
REQ-012 ch_done_o  out  8  SHALL give a one-hot one-cycle pulse at burst completion; busy_o  out  1  SHALL be high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, START, XFER and DONE.
- IDLE -> START when sched_enable_i=1 and ch_req_i/=0.
- START -> XFER unconditionally.
- XFER -> DONE when the last word's write completes.
- DONE -> IDLE unconditionally.
REQ-014 Arbitration SHALL be round-robin: the search starts at last_grant+1 mod 8 and takes the first set request bit. The grant is registered on the IDLE->START edge; last_grant is updated in DONE.
REQ-015 In START, src_start_o=1 and buf_chipselect_o SHALL be valid. Latency is therefore: request seen in IDLE at cycle N -> src_start_o at N+1 -> src_ready_o may assert at N+2.
REQ-016 In XFER, src_ready_o SHALL = (accepted < BURST_WORDS) AND (buf_write_o=0 OR selected waitrequest=0).
REQ-017 On each accepted word, on the same edge:
- buf_writedata_o <= src_data_i
- buf_address_o <= accepted count (0..BURST_WORDS-1)
- buf_write_o <= 1
- buf_byteenable_o = 8'hFF constant
REQ-018 buf_write_o, address and data SHALL hold stable while the selected waitrequest=1. The write completes on a cycle with buf_write_o=1 and waitrequest=0. buf_write_o drops after completion unless a new word is accepted on that cycle (back-to-back: one word per cycle).
REQ-019 The counter SHALL use 13 bits so BURST_WORDS=4096 never wraps; the address is its low 12 bits.
REQ-020 Deassertion of ch_req_i of the granted channel mid-burst SHALL be ignored; the burst completes.
REQ-021 src_valid_i with src_ready_o=0 SHALL neither be consumed nor altered.
REQ-022 In DONE, ch_done_o SHALL pulse the granted bit and buf_chipselect_o stays asserted. In IDLE, buf_chipselect_o=0.
REQ-023 If the finishing channel re-requests while others also request, the others SHALL be served first (fairness).

Reset
REQ-024 While reset_sink_reset=1:
- state IDLE, last_grant=7 (channel A has first priority)
- all outputs 0, src_ch_o=0, counters 0
REQ-025 Reset asserted mid-burst SHALL abort on the next edge with no done pulse; a partially written buffer is not recovered.

Verification
REQ-026 ch_req_i=8'h01, BURST_WORDS=4, source always valid, waitrequest=0 -> src_start_o at cycle 1; writes to addresses 0,1,2,3 on consecutive cycles; ch_done_o=8'h01 one cycle after the last write.
REQ-027 ch_req_i=8'hFF held for 3 bursts from reset -> grants A, B, C in order; with ch_req_i=8'h81 after C -> H, then A.
REQ-028 Selected waitrequest=1 for 3 cycles on word 2 -> buf_write_o, address 2 and data held 4 cycles; src_ready_o=0 throughout; no word lost or duplicated.
REQ-029 Granted channel's ch_req_i drops at word 1 -> all BURST_WORDS words still written and ch_done_o pulses; sched_enable_i=0 with requests pending -> busy_o stays 0.
REQ-030 Reset asserted during word 2 of 4 -> next cycle all outputs 0, no ch_done_o; after release with ch_req_i=8'h02 -> channel B granted, address restarts at 0.
REQ-031 BURST_WORDS=4096 -> final address 12'hFFF, exactly 4096 writes, one done pulse.
